// File: rtl/lif_neurons.sv
// lif_neurons: bank of leaky integrate-and-fire neurons fed by MAC lane products
module lif_neurons #(
  parameter int NUM_NEURONS = 8,
  parameter int POT_W       = 24,
  parameter int REFRAC_W    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [16*NUM_NEURONS-1:0]     ins,
  input  logic [NUM_NEURONS-1:0]        inValids,
  input  logic                          tick,
  input  logic [POT_W-1:0]              threshold,
  input  logic [3:0]                    leakShift,
  input  logic [REFRAC_W-1:0]           refracCycles,
  output logic [NUM_NEURONS-1:0]        spikes,
  output logic                          spikeValid,
  output logic [POT_W*NUM_NEURONS-1:0]  potentials,
  output logic [15:0]                   spikeCount
);
  localparam int CNT_W = $clog2(NUM_NEURONS + 1);
  localparam logic signed [POT_W-1:0] POT_MAX = {1'b0, {(POT_W-1){1'b1}}};
  localparam logic signed [POT_W-1:0] POT_MIN = {1'b1, {(POT_W-1){1'b0}}};
  logic signed [POT_W-1:0]  r_pot [NUM_NEURONS];
  logic [REFRAC_W-1:0]      r_rc [NUM_NEURONS];
  logic signed [POT_W-1:0]  w_pot_nxt [NUM_NEURONS];
  logic [REFRAC_W-1:0]      w_rc_nxt [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]   w_fire;
  logic [NUM_NEURONS-1:0]   r_spikes;
  logic                     r_spike_valid;
  logic [15:0]              r_count;
  logic [CNT_W-1:0]         w_pop;
  logic [16:0]              w_count_sum;
  for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_lane
    logic signed [POT_W-1:0] w_in, w_sat, w_v, w_leak;
    logic signed [POT_W:0]   w_sum;
    logic                    w_idle;
    assign w_idle   = r_rc[i] == '0;
    assign w_in     = {{(POT_W-16){ins[16*i+15]}}, ins[16*i +: 16]};
    // one extra bit of headroom exposes overflow so the sum clamps instead of wrapping
    assign w_sum    = {r_pot[i][POT_W-1], r_pot[i]} + {w_in[POT_W-1], w_in};
    assign w_sat    = (w_sum[POT_W] == w_sum[POT_W-1]) ? w_sum[POT_W-1:0] : (w_sum[POT_W] ? POT_MIN : POT_MAX);
    assign w_v      = (inValids[i] && w_idle) ? w_sat : r_pot[i];
    assign w_fire[i] = w_idle && (w_v >= $signed(threshold));
    assign w_leak   = (leakShift == 4'd0) ? w_v : w_v - (w_v >>> leakShift);
    assign w_pot_nxt[i] = !tick ? w_v : (w_fire[i] || !w_idle) ? '0 : w_leak;
    assign w_rc_nxt[i]  = !tick ? r_rc[i] : w_fire[i] ? refracCycles : w_idle ? r_rc[i] : r_rc[i] - REFRAC_W'(1);
    assign potentials[POT_W*i +: POT_W] = r_pot[i];
  end
  // number of lanes firing on this tick
  always_comb begin
    w_pop = '0;
    for (int k = 0; k < NUM_NEURONS; k++) w_pop += CNT_W'(w_fire[k]);
  end
  assign w_count_sum = {1'b0, r_count} + 17'(w_pop);
  // lane state, spike vector and saturating spike counter
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        r_pot[k] <= '0;
        r_rc[k]  <= '0;
      end
      r_spikes      <= '0;
      r_spike_valid <= 1'b0;
      r_count       <= '0;
    end else begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        r_pot[k] <= w_pot_nxt[k];
        r_rc[k]  <= w_rc_nxt[k];
      end
      r_spike_valid <= tick;
      if (tick) begin
        r_spikes <= w_fire;
        r_count  <= w_count_sum[16] ? 16'hFFFF : w_count_sum[15:0];
      end
    end
  end
  assign spikes     = r_spikes;
  assign spikeValid = r_spike_valid;
  assign spikeCount = r_count;
endmodule

// File: tb/tb_lif_neurons.sv
// tb_lif_neurons: directed and randomized checks of lif_neurons against an arithmetic model
module tb_lif_neurons;
  localparam int N = 8;
  localparam int PW = 24;
  localparam longint PMAX = 64'sd8388607;
  localparam longint PMIN = -64'sd8388608;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [16*N-1:0] ins = '0;
  logic [N-1:0] inValids = '0;
  logic tick = 1'b0;
  logic [PW-1:0] threshold = 24'd1000;
  logic [3:0] leakShift = '0;
  logic [3:0] refracCycles = '0;
  logic [N-1:0] spikes;
  logic spikeValid;
  logic [PW*N-1:0] potentials;
  logic [15:0] spikeCount;
  int errors = 0;
  int checks = 0;
  longint m_pot [N];
  int m_rc [N];
  logic [N-1:0] m_sp;
  logic m_spv;
  int m_cnt;

  lif_neurons dut (
    .clk(clk), .reset(reset), .ins(ins), .inValids(inValids), .tick(tick),
    .threshold(threshold), .leakShift(leakShift), .refracCycles(refracCycles),
    .spikes(spikes), .spikeValid(spikeValid), .potentials(potentials), .spikeCount(spikeCount)
  );

  always #5 clk = ~clk;

  function automatic void model_step();
    int pop;
    longint v;
    pop = 0;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_pot[i] = 0;
        m_rc[i] = 0;
      end
      m_sp = '0;
      m_spv = 1'b0;
      m_cnt = 0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      v = m_pot[i];
      if (inValids[i] && m_rc[i] == 0) begin
        v = m_pot[i] + longint'($signed(ins[16*i +: 16]));
        if (v > PMAX) v = PMAX;
        if (v < PMIN) v = PMIN;
      end
      if (!tick) m_pot[i] = v;
      else if (m_rc[i] == 0 && v >= longint'($signed(threshold))) begin
        m_sp[i] = 1'b1;
        m_pot[i] = 0;
        m_rc[i] = int'(refracCycles);
        pop++;
      end else if (m_rc[i] != 0) begin
        m_sp[i] = 1'b0;
        m_pot[i] = 0;
        m_rc[i]--;
      end else begin
        m_sp[i] = 1'b0;
        m_pot[i] = (leakShift == 0) ? v : v - (v >>> leakShift);
      end
    end
    if (tick) m_cnt = (m_cnt + pop > 65535) ? 65535 : m_cnt + pop;
    m_spv = tick;
  endfunction

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ins = '0;
    inValids = '0;
    tick = 1'b0;
    reset = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    threshold = 24'd1000;
    leakShift = '0;
    refracCycles = '0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (spikes !== '0) begin errors++; $display("FAIL reset_spikes got=%h want=0", spikes); end
    checks++;
    if (spikeValid !== 1'b0) begin errors++; $display("FAIL reset_spikeValid got=%b want=0", spikeValid); end
    checks++;
    if (spikeCount !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", spikeCount); end
    checks++;
    if (potentials !== '0) begin errors++; $display("FAIL reset_pots got=%h want=0", potentials); end
  endtask

  task automatic test_integrate();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      ins[15:0] = 16'd100;
      inValids = 8'h01;
      cyc();
    end
    idle_inputs();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    checks++;
    if (spikes !== 8'h00) begin errors++; $display("FAIL integ_spikes got=%h want=00", spikes); end
    checks++;
    if (spikeValid !== 1'b1) begin errors++; $display("FAIL integ_spikeValid got=%b want=1", spikeValid); end
    checks++;
    if (potentials[23:0] !== 24'd400) begin errors++; $display("FAIL integ_pot0 got=%0d want=400", potentials[23:0]); end
  endtask

  task automatic test_fire();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      ins[15:0] = 16'd100;
      inValids = 8'h01;
      cyc();
    end
    idle_inputs();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    checks++;
    if (spikes !== 8'h01) begin errors++; $display("FAIL fire_spikes got=%h want=01", spikes); end
    checks++;
    if (spikeValid !== 1'b1) begin errors++; $display("FAIL fire_spikeValid got=%b want=1", spikeValid); end
    checks++;
    if (potentials[23:0] !== 24'd0) begin errors++; $display("FAIL fire_pot0 got=%0d want=0", potentials[23:0]); end
    checks++;
    if (spikeCount !== 16'd1) begin errors++; $display("FAIL fire_count got=%0d want=1", spikeCount); end
    cyc();
    checks++;
    if (spikeValid !== 1'b0 || spikes !== 8'h01) begin
      errors++; $display("FAIL fire_hold got=%b/%h want=0/01", spikeValid, spikes);
    end
  endtask

  task automatic test_leak();
    do_reset();
    threshold = 24'd5;
    for (int k = 0; k < 3; k++) begin
      ins[31:16] = 16'hFFFF;
      inValids = 8'h02;
      cyc();
    end
    idle_inputs();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    checks++;
    if (spikes !== 8'h00 || potentials[47:24] !== 24'hFFFFFD) begin
      errors++; $display("FAIL neg_pot1 got=%h/%h want=00/fffffd", spikes, potentials[47:24]);
    end
    do_reset();
    threshold = 24'd10000;
    leakShift = 4'd2;
    ins[31:16] = 16'd800;
    inValids = 8'h02;
    cyc();
    idle_inputs();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    checks++;
    if (potentials[47:24] !== 24'd600) begin errors++; $display("FAIL leak_pot1 got=%0d want=600", potentials[47:24]); end
  endtask

  task automatic test_refrac();
    logic [23:0] want [6];
    logic [6:0] tk;
    do_reset();
    refracCycles = 4'd2;
    ins[47:32] = 16'd2000;
    inValids = 8'h04;
    tick = 1'b0;
    cyc();
    inValids = 8'h00;
    tick = 1'b1;
    cyc();
    checks++;
    if (spikes !== 8'h04) begin errors++; $display("FAIL refrac_fire got=%h want=04", spikes); end
    want = '{24'd0, 24'd0, 24'd0, 24'd0, 24'd500, 24'd1000};
    tk = 7'b0001010;
    ins[47:32] = 16'd500;
    inValids = 8'h04;
    for (int k = 0; k < 6; k++) begin
      tick = tk[k];
      cyc();
      checks++;
      if (potentials[71:48] !== want[k]) begin
        errors++; $display("FAIL refrac_pot2 step=%0d got=%0d want=%0d", k, potentials[71:48], want[k]);
      end
    end
    checks++;
    if (spikes !== 8'h00) begin errors++; $display("FAIL refrac_nospike got=%h want=00", spikes); end
  endtask

  task automatic test_saturate();
    logic [15:0] vals [2];
    logic [23:0] lim [2];
    vals = '{16'h7FFF, 16'h8000};
    lim = '{24'h7FFFFF, 24'h800000};
    for (int s = 0; s < 2; s++) begin
      do_reset();
      ins = {N{vals[s]}};
      inValids = '1;
      for (int k = 0; k < 300; k++) cyc();
      for (int i = 0; i < N; i++) begin
        checks++;
        if (potentials[24*i +: 24] !== lim[s]) begin
          errors++; $display("FAIL sat lane=%0d got=%h want=%h", i, potentials[24*i +: 24], lim[s]);
        end
      end
    end
  endtask

  task automatic test_reset_tick();
    do_reset();
    ins = {N{16'd2000}};
    inValids = '1;
    cyc();
    inValids = '0;
    tick = 1'b1;
    cyc();
    checks++;
    if (spikeCount !== 16'd8) begin errors++; $display("FAIL rt_precount got=%0d want=8", spikeCount); end
    tick = 1'b0;
    inValids = '1;
    cyc();
    reset = 1'b1;
    tick = 1'b1;
    cyc();
    idle_inputs();
    checks++;
    if (spikes !== '0 || spikeValid !== 1'b0) begin
      errors++; $display("FAIL rt_spikes got=%h/%b want=00/0", spikes, spikeValid);
    end
    checks++;
    if (potentials !== '0 || spikeCount !== 16'd0) begin
      errors++; $display("FAIL rt_state got=%h/%0d want=0/0", potentials, spikeCount);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    threshold = 24'h800000;
    tick = 1'b1;
    for (int k = 0; k < 8191; k++) cyc();
    checks++;
    if (spikeCount !== 16'hFFF8) begin errors++; $display("FAIL b2b_count got=%h want=fff8", spikeCount); end
    cyc();
    cyc();
    tick = 1'b0;
    checks++;
    if (spikeCount !== 16'hFFFF || spikes !== 8'hFF) begin
      errors++; $display("FAIL b2b_sat got=%h/%h want=ffff/ff", spikeCount, spikes);
    end
  endtask

  task automatic test_random();
    int t;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) ins[16*i +: 16] = 16'($urandom);
      inValids = 8'($urandom);
      tick = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 255) == 0);
      t = int'($urandom_range(0, 300000)) - 100000;
      threshold = t[23:0];
      leakShift = 4'($urandom_range(0, 15));
      refracCycles = 4'($urandom_range(0, 3));
      cyc();
      checks++;
      if (spikes !== m_sp || spikeValid !== m_spv || spikeCount !== 16'(m_cnt)) begin
        errors++; $display("FAIL rand_out cyc=%0d got=%h/%b/%0d want=%h/%b/%0d",
                           c, spikes, spikeValid, spikeCount, m_sp, m_spv, m_cnt);
      end
      for (int i = 0; i < N; i++) begin
        checks++;
        if (potentials[24*i +: 24] !== 24'(m_pot[i])) begin
          errors++; $display("FAIL rand_pot cyc=%0d lane=%0d got=%h want=%h", c, i, potentials[24*i +: 24], 24'(m_pot[i]));
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_integrate();
    test_fire();
    test_leak();
    test_refrac();
    test_saturate();
    test_reset_tick();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
